game_state_tx: RTL and testbench

//  Converts the player's start/stop switch into game-state packets for the UART transmitter.
//  The switch is synchronised and debounced before use. Each debounced edge, and optionally a

---
 rtl/game_pkt_pkg.sv | 23 ++
 rtl/gs_pkt_fifo.sv | 63 ++++++
 rtl/game_state_tx.sv | 153 +++++++++++++++
 tb/tb_game_state_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkt_pkg.sv
// Shared constants and helpers for the game-state packet transmitter.
package game_pkt_pkg;

  localparam logic [1:0] PKT_CLASS_STATE = 2'b01;
  localparam logic [1:0] ST_START        = 2'b01;
  localparam logic [1:0] ST_STOP         = 2'b10;
  localparam logic [7:0] GAME_START      = 8'h05;
  localparam logic [7:0] GAME_STOP       = 8'h09;

  // Debounce FSM encoding
  typedef enum logic [0:0] {
    DEB_STABLE = 1'b0,
    DEB_CHECK  = 1'b1
  } deb_state_e;

  // Build the state packet for the debounced switch level (1 = running)
  function automatic logic [7:0] make_pkt(input logic running);
    logic [1:0] st;
    st = running ? ST_START : ST_STOP;
    return {4'b0000, st, PKT_CLASS_STATE};
  endfunction

endpackage

// File: rtl/gs_pkt_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head.
// A pop on an empty FIFO is ignored; a push while full is only accepted
// when a pop frees a slot in the same cycle.
module gs_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Head is forced to zero when empty so the output never shows stale or unknown data
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  // Storage write
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/game_state_tx.sv
// Start/stop switch to game-state packet source for the UART TX.
// Switch -> 2-flop sync -> debounce FSM -> edge/resend events -> packet FIFO.
module game_state_tx
  import game_pkt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RESEND_CYCLES   = 0,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 3
) (
  input  logic             uart_clk,
  input  logic             rst,
  input  logic             switch,
  input  logic [CNT_W-1:0] complete_cuisine_num,
  output logic [7:0]       data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [7:0]       led,
  output logic             overflow
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;

  logic             r_sw_meta;
  logic             r_sw_s;
  deb_state_e       r_deb_fsm;
  logic [DCW-1:0]   r_cnt;
  logic             r_deb_state;
  logic             r_edge_evt;
  logic [TW-1:0]    r_timer;
  logic             r_overflow;
  logic [CNT_W-1:0] r_led_cnt;

  logic             w_resend_evt;
  logic             w_push;
  logic [7:0]       w_pkt;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [7:0]       w_led;

  // Resend fires on the last count of the period; disabled when the period is 0
  assign w_resend_evt = (RESEND_CYCLES > 0) && (r_timer == TW'(RESEND_CYCLES - 1));
  // An edge and a resend in the same cycle collapse into one packet of the (new) state
  assign w_push       = r_edge_evt || w_resend_evt;
  assign w_pkt        = make_pkt(r_deb_state);
  assign data_valid   = !w_empty;
  assign w_pop        = data_valid && data_ready;
  assign w_drop       = w_push && w_full && !w_pop;
  assign overflow     = r_overflow;

  // Two-flop synchroniser for the asynchronous switch
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_sw_meta <= 1'b0;
      r_sw_s    <= 1'b0;
    end else begin
      r_sw_meta <= switch;
      r_sw_s    <= r_sw_meta;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES samples before it is accepted
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_deb_fsm   <= DEB_STABLE;
      r_cnt       <= '0;
      r_deb_state <= 1'b0;
      r_edge_evt  <= 1'b0;
    end else begin
      r_edge_evt <= 1'b0;
      case (r_deb_fsm)
        DEB_STABLE: begin
          if (r_sw_s != r_deb_state) begin
            r_deb_fsm <= DEB_CHECK;
            r_cnt     <= DCW'(1);
          end
        end
        DEB_CHECK: begin
          if (r_sw_s == r_deb_state) begin
            r_deb_fsm <= DEB_STABLE;
          end else if (r_cnt >= DCW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb_state <= ~r_deb_state;
            r_edge_evt  <= 1'b1;
            r_deb_fsm   <= DEB_STABLE;
          end else begin
            r_cnt <= r_cnt + DCW'(1);
          end
        end
        default: begin
          r_deb_fsm <= DEB_STABLE;
        end
      endcase
    end
  end

  // Resend period timer; any accepted edge restarts the period
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (RESEND_CYCLES == 0) begin
      r_timer <= '0;
    end else if (r_edge_evt || w_resend_evt) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Registered copy of the dish count for the LEDs
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_led_cnt <= '0;
    end else begin
      r_led_cnt <= complete_cuisine_num;
    end
  end

  // LED map: count in the low bits, running state in bit 6, overflow in bit 7
  always_comb begin
    w_led             = 8'h00;
    w_led[CNT_W-1:0]  = r_led_cnt;
    w_led[6]          = r_deb_state;
    w_led[7]          = r_overflow;
  end
  assign led = w_led;

  gs_pkt_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (uart_clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_pkt),
    .i_pop   (w_pop),
    .o_rdata (data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_game_state_tx.sv
// Bench for game_state_tx: two instances (no resend / resend every 10 cycles)
// driven by the same inputs and tracked by a behavioural run-length model.
module tb_game_state_tx;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int RES1  = 10;

  logic          uart_clk = 1'b0;
  logic          rst = 1'b1;
  logic          switch = 1'b0;
  logic          data_ready = 1'b1;
  logic [CW-1:0] cuisine = '0;
  logic [7:0]    data0, data1, led0, led1;
  logic          dv0, dv1, ovf0, ovf1;

  int total = 0;
  int bad = 0;

  // Model state
  logic          m_sw1, m_sw2, m_deb, m_flip;
  int            m_run;
  logic [7:0]    m_f [2][DEPTH];
  int            m_n [2];
  int            m_tmr [2];
  logic          m_ovf [2];
  logic [CW-1:0] m_ledc;

  always #5 uart_clk = ~uart_clk;

  game_state_tx #(.DEBOUNCE_CYCLES(DEB), .RESEND_CYCLES(0), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut0 (
    .uart_clk(uart_clk), .rst(rst), .switch(switch), .complete_cuisine_num(cuisine),
    .data(data0), .data_valid(dv0), .data_ready(data_ready), .led(led0), .overflow(ovf0));

  game_state_tx #(.DEBOUNCE_CYCLES(DEB), .RESEND_CYCLES(RES1), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut1 (
    .uart_clk(uart_clk), .rst(rst), .switch(switch), .complete_cuisine_num(cuisine),
    .data(data1), .data_valid(dv1), .data_ready(data_ready), .led(led1), .overflow(ovf1));

  function automatic int res_of(int k);
    return (k == 1) ? RES1 : 0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs present at that edge
  task automatic model_step();
    logic       push, pop, flip_now;
    logic [7:0] pkt;
    if (rst) begin
      m_sw1 = 1'b0; m_sw2 = 1'b0; m_deb = 1'b0; m_flip = 1'b0; m_run = 0; m_ledc = '0;
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_tmr[k] = 0; m_ovf[k] = 1'b0;
      end
      return;
    end
    pkt = m_deb ? 8'h05 : 8'h09;
    for (int k = 0; k < 2; k++) begin
      push = m_flip || (res_of(k) > 0 && m_tmr[k] == res_of(k) - 1);
      pop  = (m_n[k] > 0) && data_ready;
      if (push && m_n[k] == DEPTH && !pop) m_ovf[k] = 1'b1;
      if (pop) begin
        for (int j = 0; j < DEPTH - 1; j++) m_f[k][j] = m_f[k][j+1];
        m_n[k]--;
      end
      if (push && m_n[k] < DEPTH) begin
        m_f[k][m_n[k]] = pkt;
        m_n[k]++;
      end
      if (res_of(k) > 0)
        m_tmr[k] = (m_flip || m_tmr[k] == res_of(k) - 1) ? 0 : m_tmr[k] + 1;
    end
    flip_now = 1'b0;
    if (m_sw2 != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = ~m_deb; m_run = 0; flip_now = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    m_flip = flip_now;
    m_sw2  = m_sw1;
    m_sw1  = switch;
    m_ledc = cuisine;
  endtask

  task automatic tick();
    @(posedge uart_clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    rst = 1'b1; switch = 1'b0; data_ready = 1'b1; cuisine = '0;
    tick(); tick();
    total++; if (dv0 !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", dv0); end
    total++; if (data0 !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data0); end
    total++; if (led0 !== 8'h00)  begin bad++; $display("FAIL reset_led: got %h want 00", led0); end
    total++; if (ovf0 !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    total++; if (dv1 !== 1'b0)   begin bad++; $display("FAIL reset_valid1: got %b want 0", dv1); end
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      total++; if (dv0 !== 1'b0 || dv1 !== 1'b0) begin
        bad++; $display("FAIL release_no_pkt: cycle %0d got %b/%b want 0/0", c, dv0, dv1);
      end
    end
  endtask

  task automatic test_start_stop();
    logic [7:0] exp;
    for (int p = 0; p < 2; p++) begin
      switch = (p == 0);
      exp = (p == 0) ? 8'h05 : 8'h09;
      for (int c = 1; c <= 8; c++) begin
        tick();
        total++; if (dv0 !== (c == 7)) begin
          bad++; $display("FAIL latency_valid: phase %0d cycle %0d got %b want %b", p, c, dv0, (c == 7));
        end
        if (c == 7) begin
          total++; if (data0 !== exp) begin bad++; $display("FAIL pkt_data: got %h want %h", data0, exp); end
          total++; if (led0[6] !== (p == 0)) begin bad++; $display("FAIL led6_run: got %b want %b", led0[6], (p == 0)); end
        end
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_glitch();
    switch = 1'b1;
    repeat (3) tick();
    switch = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dv0 !== 1'b0 || led0[6] !== 1'b0) begin
        bad++; $display("FAIL glitch: cycle %0d got valid=%b led6=%b want 0/0", c, dv0, led0[6]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    exp[0] = 8'h05; exp[1] = 8'h09; exp[2] = 8'h05; exp[3] = 8'h09;
    data_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      switch = ~switch;
      repeat (8) tick();
      if (t == 3) begin
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf0); end
      end
    end
    total++; if (ovf0 !== 1'b1)    begin bad++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    total++; if (led0[7] !== 1'b1) begin bad++; $display("FAIL led7: got %b want 1", led0[7]); end
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (dv0 !== 1'b1 || data0 !== exp[i]) begin
        bad++; $display("FAIL drain_order: slot %0d got %b/%h want 1/%h", i, dv0, data0, exp[i]);
      end
      tick();
    end
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", dv0); end
  endtask

  task automatic test_resend();
    int found;
    rst = 1'b1; switch = 1'b1; data_ready = 1'b1;
    tick();
    rst = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      tick();
      if (dv1 === 1'b1) found = 1;
    end
    total++; if (found == 0) begin bad++; $display("FAIL resend_first: got none want packet within 30 cycles"); end
    total++; if (data1 !== 8'h05) begin bad++; $display("FAIL resend_first_data: got %h want 05", data1); end
    for (int t = 1; t <= 10; t++) begin
      tick();
      total++; if (dv1 !== (t == 10) || (t == 10 && data1 !== 8'h05)) begin
        bad++; $display("FAIL resend_period: t %0d got %b/%h want %b/05", t, dv1, data1, (t == 10));
      end
    end
    found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      if (m_tmr[1] == 3) found = 1; else tick();
    end
    total++; if (found == 0) begin bad++; $display("FAIL resend_align: got no alignment want timer 3"); end
    switch = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      tick();
      total++; if (dv1 !== (c == 7 || c == 17 || c == 27)) begin
        bad++; $display("FAIL resend_collide: cycle %0d got %b want %b", c, dv1, (c == 7 || c == 17 || c == 27));
      end else if (dv1 === 1'b1 && data1 !== 8'h09) begin
        bad++; $display("FAIL resend_collide_data: cycle %0d got %h want 09", c, data1);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    exp[0] = 8'h09; exp[1] = 8'h05; exp[2] = 8'h09; exp[3] = 8'h05;
    rst = 1'b1; switch = 1'b0;
    tick();
    rst = 1'b0; data_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      switch = ~switch;
      repeat (8) tick();
    end
    switch = 1'b1;
    repeat (6) tick();
    data_ready = 1'b1;
    tick();
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf: got %b want 0", ovf0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dv0 !== 1'b1 || data0 !== exp[i]) begin
        bad++; $display("FAIL full_pushpop_order: slot %0d got %b/%h want 1/%h", i, dv0, data0, exp[i]);
      end
      tick();
    end
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL full_pushpop_empty: got %b want 0", dv0); end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      switch = ~switch;
      repeat (8) tick();
    end
    total++; if (dv0 !== 1'b1) begin bad++; $display("FAIL mid_queued: got %b want 1", dv0); end
    cuisine = 3'd5; switch = 1'b1; rst = 1'b1; data_ready = 1'b1;
    tick();
    total++; if (dv0 !== 1'b0 || led0 !== 8'h00 || ovf0 !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got valid=%b led=%h ovf=%b want 0/00/0", dv0, led0, ovf0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        total++; if (led0 !== 8'h05) begin bad++; $display("FAIL mid_led_cnt: got %h want 05", led0); end
      end
      total++; if (dv0 !== (c == 7) || (c == 7 && data0 !== 8'h05)) begin
        bad++; $display("FAIL mid_restart: cycle %0d got %b/%h want %b/05", c, dv0, data0, (c == 7));
      end
    end
  endtask

  task automatic test_random();
    int         hold;
    logic [7:0] gd, gl, ed, el;
    logic       gv, go, ev;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        switch = ~switch;
        hold = $urandom_range(1, 12);
      end
      hold--;
      data_ready = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cuisine = CW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 399) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        gv = (k == 0) ? dv0 : dv1;
        gd = (k == 0) ? data0 : data1;
        gl = (k == 0) ? led0 : led1;
        go = (k == 0) ? ovf0 : ovf1;
        ev = (m_n[k] > 0);
        ed = ev ? m_f[k][0] : 8'h00;
        el = {m_ovf[k], m_deb, 3'b000, m_ledc};
        total++; if (gv !== ev || gd !== ed) begin
          bad++; $display("FAIL rand_pkt: dut%0d cycle %0d got %b/%h want %b/%h", k, c, gv, gd, ev, ed);
        end
        total++; if (gl !== el || go !== m_ovf[k]) begin
          bad++; $display("FAIL rand_status: dut%0d cycle %0d got led=%h ovf=%b want led=%h ovf=%b", k, c, gl, go, el, m_ovf[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_glitch();
    test_backpressure();
    test_resend();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
